// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  // Fetch FSM: idle, response pending and kept, response pending and discarded
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_stage_fifo.sv
// Small synchronous instruction buffer of {pc, instr} entries.
// Flush wins over push and pop; the fetch stage never pushes into a full
// buffer unless it pops in the same cycle.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [31:0]              i_pc,
  input  logic [31:0]              i_instr,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_head_vld,
  output logic [31:0]              o_head_pc,
  output logic [31:0]              o_head_instr
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_count;
  logic          w_pop;

  // A pop on an empty buffer is meaningless; ignore it rather than wrap
  assign w_pop = i_pop && (r_count != '0);

  // Pointer and occupancy tracking; flush empties the buffer in one edge
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents only matter while counted, so no reset
  always_ff @(posedge clk) begin
    if (!reset && !i_flush && i_push)
      r_mem[r_wr] <= '{pc: i_pc, instr: i_instr};
  end

  assign o_count      = r_count;
  assign o_head_vld   = (r_count != '0);
  assign o_head_pc    = r_mem[r_rd].pc;
  assign o_head_instr = r_mem[r_rd].instr;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one imem
// request in flight, buffers returned words so hazard stalls lose nothing,
// and discards stale responses after a branch/jump redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_IF,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        valid_IF,
  output logic [31:0] instruction_IF,
  output logic [31:0] pcPlus4_IF
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  fetch_state_e r_state;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_req_pc;

  logic [CW-1:0] w_count;
  logic          w_head_vld;
  logic [31:0]   w_head_pc;
  logic [31:0]   w_head_instr;
  logic          w_outstanding;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [SW-1:0] w_reserved;

  assign w_outstanding = (r_state != FETCH_IDLE);
  assign w_pop         = w_head_vld && !stall_IF;

  // Slots already used or promised; a pop this cycle frees one, which is
  // what lets push and pop coincide on a full buffer without overflow.
  assign w_reserved = SW'(w_count) + SW'(w_outstanding) - SW'(w_pop);

  // A new request may go out when nothing is pending or the pending one
  // completes this cycle, and the buffer has room for its eventual word.
  assign w_issue = !reset && !redirect
                && ((r_state == FETCH_IDLE) || imem_rvalid)
                && (w_reserved < SW'(FIFO_DEPTH));

  assign w_push = !reset && !redirect && (r_state == FETCH_WAIT) && imem_rvalid;

  // FSM, fetch PC and the side register holding the in-flight request's PC
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FETCH_IDLE;
      r_fetch_pc <= word_align(RESET_VECTOR);
      r_req_pc   <= '0;
    end else if (redirect) begin
      r_fetch_pc <= word_align(redirect_target);
      if (w_outstanding && !imem_rvalid) r_state <= FETCH_DROP;
      else                               r_state <= FETCH_IDLE;
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_req_pc   <= r_fetch_pc;
      end
      case (r_state)
        FETCH_IDLE: r_state <= w_issue ? FETCH_WAIT : FETCH_IDLE;
        FETCH_WAIT,
        FETCH_DROP: if (imem_rvalid) r_state <= w_issue ? FETCH_WAIT : FETCH_IDLE;
        default:    r_state <= FETCH_IDLE;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_pop        (w_pop && !redirect),
    .i_flush      (redirect),
    .i_pc         (r_req_pc),
    .i_instr      (imem_rdata),
    .o_count      (w_count),
    .o_head_vld   (w_head_vld),
    .o_head_pc    (w_head_pc),
    .o_head_instr (w_head_instr)
  );

  assign imem_req       = w_issue;
  assign imem_addr      = w_issue ? r_fetch_pc : 32'h0;
  assign valid_IF       = w_head_vld;
  assign instruction_IF = w_head_vld ? w_head_instr : NOP_WORD;
  assign pcPlus4_IF     = w_head_vld ? (w_head_pc + 32'd4) : 32'h0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural one-outstanding memory
// whose latency is set per scenario.
module tb_fetch_stage;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_IF;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        valid_IF;
  logic [31:0] instruction_IF;
  logic [31:0] pcPlus4_IF;

  int n_chk;
  int n_err;

  // memory model state
  int          lat;
  logic        m_pend;
  logic [31:0] m_addr;
  int          m_cnt;

  fetch_stage #(.RESET_VECTOR(RV), .FIFO_DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .stall_IF        (stall_IF),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .valid_IF        (valid_IF),
    .instruction_IF  (instruction_IF),
    .pcPlus4_IF      (pcPlus4_IF)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents keyed on the low half of the address
  function automatic logic [31:0] word(input logic [31:0] a);
    if (a[15:0] == 16'h0000)      return 32'h2008_0005;
    else if (a[15:0] == 16'h0004) return 32'h2009_0003;
    else                          return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample what the DUT presents, cross the edge, then advance
  // the memory so its response appears lat cycles after the request.
  task automatic step();
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_rv;
    logic        s_rst;
    s_req  = imem_req;
    s_addr = imem_addr;
    s_rv   = imem_rvalid;
    s_rst  = reset;
    chk("one_outstanding", {31'b0, s_req && m_pend && !s_rv}, 32'h0);
    @(posedge clk);
    #1;
    if (s_rv || s_rst) m_pend = 1'b0;
    if (s_req) begin
      m_pend = 1'b1;
      m_addr = s_addr;
      m_cnt  = lat - 1;
    end else if (m_pend) begin
      m_cnt = m_cnt - 1;
    end
    imem_rvalid = m_pend && (m_cnt == 0);
    imem_rdata  = imem_rvalid ? word(m_addr) : 32'hDEAD_BEEF;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    stall_IF = 1'b0;
    step();
    step();
    #1;
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, valid_IF}, 32'h0);
    chk("rst_instr", instruction_IF,    32'h0);
    chk("rst_pc4",   pcPlus4_IF,        32'h0);
    reset = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    reset = 1'b1; stall_IF = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    m_pend = 1'b0; m_addr = 32'h0; m_cnt = 0; lat = 1;

    // ---- 1: latency-1 streaming from the reset vector
    do_reset();
    #1; chk("t1_req0", {31'b0, imem_req}, 32'h1); chk("t1_addr0", imem_addr, RV);
    step();
    #1; chk("t1_v0", {31'b0, valid_IF}, 32'h0); chk("t1_addr1", imem_addr, RV + 4);
    step();
    #1; chk("t1_v1", {31'b0, valid_IF}, 32'h1);
    chk("t1_pc4a", pcPlus4_IF, RV + 4); chk("t1_insa", instruction_IF, 32'h2008_0005);
    step();

    // ---- 2: stall for 5 cycles, buffer fills to 2, no extra request
    stall_IF = 1'b1;
    #1; chk("t2_pc4b", pcPlus4_IF, RV + 8); chk("t2_insb", instruction_IF, 32'h2009_0003);
    chk("t2_noreq0", {31'b0, imem_req}, 32'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      #1; chk("t2_noreq", {31'b0, imem_req}, 32'h0); chk("t2_hold", pcPlus4_IF, RV + 8);
      step();
    end
    stall_IF = 1'b0;
    #1; chk("t2_rel_pc4", pcPlus4_IF, RV + 8); chk("t2_rel_addr", imem_addr, RV + 32'hC);
    step();
    #1; chk("t2_pc4c", pcPlus4_IF, RV + 32'hC); chk("t2_insc", instruction_IF, 32'hC0DE_0008);
    step();
    #1; chk("t2_pc4d", pcPlus4_IF, RV + 32'h10); chk("t2_insd", instruction_IF, 32'hC0DE_000C);

    // ---- 3: redirect while a latency-2 request to 0x0C is in flight
    do_reset();
    lat = 2;
    redirect = 1'b1; redirect_target = 32'h0000_0008;
    #1; chk("t3_noreq_rd", {31'b0, imem_req}, 32'h0);
    step();
    redirect = 1'b0;
    #1; chk("t3_addr8", imem_addr, 32'h8);
    step();
    #1; chk("t3_wait", {31'b0, imem_req}, 32'h0);
    step();
    #1; chk("t3_addrC", imem_addr, 32'hC); chk("t3_reqC", {31'b0, imem_req}, 32'h1);
    step();
    #1; chk("t3_pc4", pcPlus4_IF, 32'hC);
    redirect = 1'b1; redirect_target = 32'h0000_0040;
    #1; chk("t3_noreq_rd2", {31'b0, imem_req}, 32'h0);
    step();
    redirect = 1'b0;
    #1; chk("t3_flushed", {31'b0, valid_IF}, 32'h0); chk("t3_addr40", imem_addr, 32'h40);
    step();
    #1; chk("t3_dropped", {31'b0, valid_IF}, 32'h0);
    step();
    #1; chk("t3_empty", {31'b0, valid_IF}, 32'h0);
    step();
    #1; chk("t3_v44", {31'b0, valid_IF}, 32'h1); chk("t3_pc44", pcPlus4_IF, 32'h44);
    chk("t3_ins40", instruction_IF, 32'hC0DE_0040);

    // ---- 4: redirect in the same cycle as the response
    do_reset();
    lat = 1;
    #1; chk("t4_addr0", imem_addr, RV);
    step();
    redirect = 1'b1; redirect_target = 32'h0000_0080;
    #1; chk("t4_noreq", {31'b0, imem_req}, 32'h0);
    step();
    redirect = 1'b0;
    #1; chk("t4_v0", {31'b0, valid_IF}, 32'h0);
    chk("t4_req80", {31'b0, imem_req}, 32'h1); chk("t4_addr80", imem_addr, 32'h80);
    step();
    #1; chk("t4_v1", {31'b0, valid_IF}, 32'h0);
    step();
    #1; chk("t4_pc84", pcPlus4_IF, 32'h84); chk("t4_ins80", instruction_IF, 32'hC0DE_0080);

    // ---- 5: reset pulse mid-WAIT with latency 3
    do_reset();
    lat = 3;
    #1; chk("t5_addr0", imem_addr, RV);
    step();
    reset = 1'b1;
    #1; chk("t5_rst_req", {31'b0, imem_req}, 32'h0);
    step();
    reset = 1'b0;
    #1; chk("t5_valid", {31'b0, valid_IF}, 32'h0); chk("t5_instr", instruction_IF, 32'h0);
    chk("t5_pc4", pcPlus4_IF, 32'h0); chk("t5_restart", imem_addr, RV);
    chk("t5_req", {31'b0, imem_req}, 32'h1);
    step();
    for (int i = 0; i < 3; i++) begin
      #1; chk("t5_wait", {31'b0, valid_IF}, 32'h0);
      step();
    end
    #1; chk("t5_pc4v", pcPlus4_IF, RV + 4); chk("t5_ins", instruction_IF, 32'h2008_0005);

    // ---- 6: unaligned redirect target, then 32-bit PC wrap
    do_reset();
    lat = 1;
    redirect = 1'b1; redirect_target = 32'h0000_0103;
    #1; chk("t6_noreq", {31'b0, imem_req}, 32'h0);
    step();
    redirect = 1'b0;
    #1; chk("t6_align", imem_addr, 32'h0000_0100);
    step();
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    #1; chk("t6_addrtop", imem_addr, 32'hFFFF_FFFC);
    step();
    #1; chk("t6_wrap", imem_addr, 32'h0); chk("t6_wrapreq", {31'b0, imem_req}, 32'h1);
    step();
    #1; chk("t6_pc4wrap", pcPlus4_IF, 32'h0); chk("t6_instop", instruction_IF, 32'hC0DE_FFFC);
    step();
    #1; chk("t6_pc4", pcPlus4_IF, 32'h4); chk("t6_ins0", instruction_IF, 32'h2008_0005);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
